// File: rtl/hu_audiodec_dma_sched.sv
// hu_audiodec_dma_sched
//
// Chunked load/compute/store scheduler for the audio decoder accelerator.
// For each chunk it issues a DMA read request, gates read beats into the load
// buffer, starts the kernel, issues a DMA write request, then drains store beats.
// After the last chunk it pulses acc_done.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   acc_start, cfg_*               start pulse and run configuration
//   dma_read_ctrl_*                read request {size, length, index}
//   dma_read_chnl_*, ld_buf_rdy    read data channel gating, ld_wr beat strobe
//   dma_write_ctrl_*               write request {size, length, index}
//   dma_write_chnl_*, st_buf_val   write data channel gating, st_rd beat strobe
//   kern_start, kern_done          per-chunk kernel handshake
//   acc_done                       one-cycle completion pulse
//   debug                          {state, err, 12'b0, chunk_idx[15:0]}
//
// Optional feature: define HU_AUDIODEC_SCHED_WDOG_EN to enable a progress
// watchdog that aborts a stuck run after WDOG_CYCLES idle cycles and sets err.

module hu_audiodec_dma_sched #(
  parameter logic [2:0]  SIZE_CODE   = 3'b011,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned WDOG_CYCLES = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             acc_start,
  input  logic [31:0]      cfg_in_base,
  input  logic [31:0]      cfg_out_base,
  input  logic [CNT_W-1:0] cfg_num_chunks,
  input  logic [CNT_W-1:0] cfg_chunk_len,
  output logic             dma_read_ctrl_val,
  input  logic             dma_read_ctrl_rdy,
  output logic [66:0]      dma_read_ctrl_msg,
  input  logic             dma_read_chnl_val,
  output logic             dma_read_chnl_rdy,
  input  logic             ld_buf_rdy,
  output logic             ld_wr,
  output logic             dma_write_ctrl_val,
  input  logic             dma_write_ctrl_rdy,
  output logic [66:0]      dma_write_ctrl_msg,
  output logic             dma_write_chnl_val,
  input  logic             dma_write_chnl_rdy,
  input  logic             st_buf_val,
  output logic             st_rd,
  output logic             kern_start,
  input  logic             kern_done,
  output logic             acc_done,
  output logic [31:0]      debug
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StRdReq   = 3'd1,
    StLoad    = 3'd2,
    StCompute = 3'd3,
    StWrReq   = 3'd4,
    StStore   = 3'd5,
    StDone    = 3'd6
  } state_e;

  localparam logic [CNT_W-1:0] One = CNT_W'(1);

  state_e           state_q;
  logic [CNT_W-1:0] num_q, len_q, chunk_q, beat_q;
  logic [31:0]      rd_idx_q, wr_idx_q;
  logic             kern_start_q;

  logic             wdog_fire;
  logic             err;
  logic             rd_req, wr_req, rd_hs, wr_hs;
  logic             last_beat, kern_accept;
  logic [31:0]      len32;
  logic [15:0]      chunk16;

  assign len32   = 32'(len_q);
  assign chunk16 = 16'(chunk_q);

  // Request and channel outputs; all of them drop in a watchdog abort cycle.
  assign rd_req = (state_q == StRdReq) & ~wdog_fire;
  assign wr_req = (state_q == StWrReq) & ~wdog_fire;
  assign rd_hs  = rd_req & dma_read_ctrl_rdy;
  assign wr_hs  = wr_req & dma_write_ctrl_rdy;

  assign dma_read_ctrl_val  = rd_req;
  assign dma_read_ctrl_msg  = rd_req ? {SIZE_CODE, len32, rd_idx_q} : '0;
  assign dma_write_ctrl_val = wr_req;
  assign dma_write_ctrl_msg = wr_req ? {SIZE_CODE, len32, wr_idx_q} : '0;

  assign dma_read_chnl_rdy  = (state_q == StLoad) & ld_buf_rdy & ~wdog_fire;
  assign ld_wr              = dma_read_chnl_val & dma_read_chnl_rdy;
  assign dma_write_chnl_val = (state_q == StStore) & st_buf_val & ~wdog_fire;
  assign st_rd              = dma_write_chnl_val & dma_write_chnl_rdy;

  assign last_beat   = (beat_q == len_q - One);
  // kern_done in the kern_start cycle belongs to no chunk of ours
  assign kern_accept = (state_q == StCompute) & ~kern_start_q & kern_done;

  assign kern_start = kern_start_q;
  assign acc_done   = (state_q == StDone);
  assign debug      = {state_q, err, 12'b0, chunk16};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      num_q        <= '0;
      len_q        <= '0;
      chunk_q      <= '0;
      beat_q       <= '0;
      rd_idx_q     <= '0;
      wr_idx_q     <= '0;
      kern_start_q <= 1'b0;
    end else begin
      kern_start_q <= 1'b0;
      if (wdog_fire) begin
        state_q <= StDone;
      end else begin
        case (state_q)
          StIdle: begin
            if (acc_start) begin
              num_q    <= cfg_num_chunks;
              len_q    <= cfg_chunk_len;
              chunk_q  <= '0;
              beat_q   <= '0;
              rd_idx_q <= cfg_in_base;
              wr_idx_q <= cfg_out_base;
              if (cfg_num_chunks == '0 || cfg_chunk_len == '0) begin
                state_q <= StDone;
              end else begin
                state_q <= StRdReq;
              end
            end
          end
          StRdReq: begin
            if (rd_hs) state_q <= StLoad;
          end
          StLoad: begin
            if (ld_wr) begin
              if (last_beat) begin
                beat_q       <= '0;
                kern_start_q <= 1'b1;
                state_q      <= StCompute;
              end else begin
                beat_q <= beat_q + One;
              end
            end
          end
          StCompute: begin
            if (kern_accept) state_q <= StWrReq;
          end
          StWrReq: begin
            if (wr_hs) state_q <= StStore;
          end
          StStore: begin
            if (st_rd) begin
              if (last_beat) begin
                beat_q   <= '0;
                rd_idx_q <= rd_idx_q + len32;
                wr_idx_q <= wr_idx_q + len32;
                chunk_q  <= chunk_q + One;
                state_q  <= (chunk_q == num_q - One) ? StDone : StRdReq;
              end else begin
                beat_q <= beat_q + One;
              end
            end
          end
          StDone: begin
            state_q <= StIdle;
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

`ifdef HU_AUDIODEC_SCHED_WDOG_EN
  logic [31:0] wdog_q;
  logic        err_q;
  logic        progress;

  // Leaving IDLE/DONE needs no handshake; every other transition coincides
  // with one of the handshake strobes or kern_done, so this covers state changes.
  assign progress = rd_hs | wr_hs | ld_wr | st_rd | kern_done |
                    (state_q == StIdle) | (state_q == StDone);

  assign wdog_fire = (state_q != StIdle) && (state_q != StDone) &&
                     (wdog_q >= 32'(WDOG_CYCLES) - 32'd1);
  assign err       = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (progress || wdog_fire) begin
        wdog_q <= '0;
      end else begin
        wdog_q <= wdog_q + 32'd1;
      end
      if (wdog_fire) begin
        err_q <= 1'b1;
      end else if (state_q == StIdle && acc_start) begin
        err_q <= 1'b0;
      end
    end
  end
`else
  assign wdog_fire = 1'b0;
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_hu_audiodec_dma_sched.sv
module tb_hu_audiodec_dma_sched;

  logic        clk;
  logic        rst;
  logic        acc_start;
  logic [31:0] cfg_in_base, cfg_out_base;
  logic [15:0] cfg_num_chunks, cfg_chunk_len;
  logic        dma_read_ctrl_val, dma_read_ctrl_rdy;
  logic [66:0] dma_read_ctrl_msg;
  logic        dma_read_chnl_val, dma_read_chnl_rdy;
  logic        ld_buf_rdy, ld_wr;
  logic        dma_write_ctrl_val, dma_write_ctrl_rdy;
  logic [66:0] dma_write_ctrl_msg;
  logic        dma_write_chnl_val, dma_write_chnl_rdy;
  logic        st_buf_val, st_rd;
  logic        kern_start, kern_done, acc_done;
  logic [31:0] debug;

  hu_audiodec_dma_sched #(
    .SIZE_CODE  (3'b011),
    .CNT_W      (16),
    .WDOG_CYCLES(100)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .acc_start         (acc_start),
    .cfg_in_base       (cfg_in_base),
    .cfg_out_base      (cfg_out_base),
    .cfg_num_chunks    (cfg_num_chunks),
    .cfg_chunk_len     (cfg_chunk_len),
    .dma_read_ctrl_val (dma_read_ctrl_val),
    .dma_read_ctrl_rdy (dma_read_ctrl_rdy),
    .dma_read_ctrl_msg (dma_read_ctrl_msg),
    .dma_read_chnl_val (dma_read_chnl_val),
    .dma_read_chnl_rdy (dma_read_chnl_rdy),
    .ld_buf_rdy        (ld_buf_rdy),
    .ld_wr             (ld_wr),
    .dma_write_ctrl_val(dma_write_ctrl_val),
    .dma_write_ctrl_rdy(dma_write_ctrl_rdy),
    .dma_write_ctrl_msg(dma_write_ctrl_msg),
    .dma_write_chnl_val(dma_write_chnl_val),
    .dma_write_chnl_rdy(dma_write_chnl_rdy),
    .st_buf_val        (st_buf_val),
    .st_rd             (st_rd),
    .kern_start        (kern_start),
    .kern_done         (kern_done),
    .acc_done          (acc_done),
    .debug             (debug)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mode: 0 all ready, 1 backpressure, 2 acc_start re-pulsed in LOAD,
  //       3 kern_done held high, 4 kern_done never sent
  typedef struct {
    logic [31:0] in_base;
    logic [31:0] out_base;
    logic [15:0] chunks;
    logic [15:0] len;
    int          kd;
    int          mode;
    logic [31:0] exp_rd_last;
    logic [31:0] exp_wr_last;
    int          exp_beats;
    int          exp_kern;
    int          exp_done_cyc;  // cycles after the start edge; 0 = not checked
  } vec_t;

  vec_t vecs[8];

  int n_vec = 0;
  int n_bad = 0;

  int          s_rd_hs, s_wr_hs, s_ld, s_st, s_kern, s_done, s_done_cyc;
  logic [31:0] s_rd_last, s_wr_last, s_dbg_done;

  task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_job(input vec_t v, input int id);
    int          stall;
    int          kd;
    bit          armed;
    bit          done_seen;
    int          cyc;
    int          extra;
    logic [66:0] exp_msg;
    s_rd_hs = 0; s_wr_hs = 0; s_ld = 0; s_st = 0; s_kern = 0; s_done = 0;
    s_done_cyc = -1; s_rd_last = '0; s_wr_last = '0; s_dbg_done = '0;
    stall = 0; kd = 0; armed = 0; done_seen = 0; cyc = 0; extra = 0;
    @(negedge clk);
    cfg_in_base    = v.in_base;
    cfg_out_base   = v.out_base;
    cfg_num_chunks = v.chunks;
    cfg_chunk_len  = v.len;
    acc_start      = 1'b1;
    @(posedge clk);
    #1;
    acc_start = 1'b0;
    while (extra < 4 && cyc < 3000) begin
      cyc++;
      kern_done = (v.mode == 3);
      if (armed) begin
        kd--;
        if (kd == 0) begin
          kern_done = 1'b1;
          armed = 0;
        end
      end
      acc_start = (v.mode == 2 && cyc == 3);
      if (acc_start) begin
        cfg_num_chunks = 16'd5;
        cfg_chunk_len  = 16'd2;
        cfg_in_base    = 32'hDEAD0000;
      end
      dma_read_chnl_val  = 1'b1;
      st_buf_val         = 1'b1;
      dma_write_ctrl_rdy = 1'b1;
      if (v.mode == 1) begin
        dma_read_ctrl_rdy  = (stall >= 5);
        ld_buf_rdy         = 1'($urandom_range(1, 0));
        dma_write_chnl_rdy = 1'($urandom_range(1, 0));
      end else begin
        dma_read_ctrl_rdy  = 1'b1;
        ld_buf_rdy         = 1'b1;
        dma_write_chnl_rdy = 1'b1;
      end
      #1;
      if (dma_read_ctrl_val) begin
        exp_msg = {3'b011, 32'(v.len), v.in_base + 32'(s_rd_hs) * 32'(v.len)};
        chk($sformatf("v%0d_rd_msg", id), 200'(dma_read_ctrl_msg), 200'(exp_msg));
        if (dma_read_ctrl_rdy) begin
          s_rd_hs++;
          s_rd_last = dma_read_ctrl_msg[31:0];
          stall = 0;
        end else begin
          stall++;
        end
      end
      if (dma_write_ctrl_val) begin
        exp_msg = {3'b011, 32'(v.len), v.out_base + 32'(s_wr_hs) * 32'(v.len)};
        chk($sformatf("v%0d_wr_msg", id), 200'(dma_write_ctrl_msg), 200'(exp_msg));
        if (dma_write_ctrl_rdy) begin
          s_wr_hs++;
          s_wr_last = dma_write_ctrl_msg[31:0];
        end
      end
      if (ld_wr) s_ld++;
      if (st_rd) s_st++;
      if (kern_start) begin
        s_kern++;
        if (v.mode != 3 && v.mode != 4) begin
          armed = 1;
          kd = v.kd;
        end
      end
      if (acc_done) begin
        s_done++;
        if (!done_seen) begin
          s_done_cyc = cyc;
          s_dbg_done = debug;
          done_seen  = 1;
        end
      end
      if (done_seen) extra++;
      @(posedge clk);
      #1;
    end
    acc_start = 1'b0;
    kern_done = 1'b0;
    if (!done_seen) begin
      n_vec++;
      n_bad++;
      $display("FAIL v%0d_timeout: got no acc_done, expected one within 3000 cycles", id);
    end
  endtask

  initial begin
    int          cyc;
    int          dcount;
    bit          seen_st;
    logic [199:0] outs;

    //            in_base        out_base      ch  len kd m  rd_last        wr_last       bt kn done
    vecs[0] = '{32'h0000_0100, 32'h0000_0800, 1, 4, 3, 0, 32'h0000_0100, 32'h0000_0800, 4, 1, 15};
    vecs[1] = '{32'h0000_0100, 32'h0000_0800, 3, 8, 3, 0, 32'h0000_0110, 32'h0000_0810, 24, 3, 67};
    vecs[2] = '{32'h0000_0100, 32'h0000_0800, 2, 6, 2, 1, 32'h0000_0106, 32'h0000_0806, 12, 2, 0};
    // degenerate: done in the cycle after the start is sampled (2nd cycle counting the start cycle)
    vecs[3] = '{32'h0000_0100, 32'h0000_0800, 0, 4, 3, 0, 32'h0, 32'h0, 0, 0, 1};
    vecs[4] = '{32'h0000_0040, 32'h0000_0080, 3, 0, 3, 0, 32'h0, 32'h0, 0, 0, 1};
    vecs[5] = '{32'h0000_0200, 32'h0000_0A00, 1, 4, 3, 2, 32'h0000_0200, 32'h0000_0A00, 4, 1, 15};
    vecs[6] = '{32'hFFFF_FFFC, 32'h0000_0010, 2, 4, 1, 0, 32'h0000_0000, 32'h0000_0014, 8, 2, 25};
    vecs[7] = '{32'h0000_0300, 32'h0000_0900, 1, 4, 1, 3, 32'h0000_0300, 32'h0000_0900, 4, 1, 13};

    rst = 1'b1;
    acc_start = 1'b0;
    cfg_in_base = '0; cfg_out_base = '0; cfg_num_chunks = '0; cfg_chunk_len = '0;
    dma_read_ctrl_rdy = 1'b1; dma_read_chnl_val = 1'b1; ld_buf_rdy = 1'b1;
    dma_write_ctrl_rdy = 1'b1; dma_write_chnl_rdy = 1'b1; st_buf_val = 1'b1;
    kern_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    outs = 200'({dma_read_ctrl_val, dma_read_ctrl_msg, dma_read_chnl_rdy, ld_wr,
                 dma_write_ctrl_val, dma_write_ctrl_msg, dma_write_chnl_val, st_rd,
                 kern_start, acc_done, debug});
    chk("reset_outputs", outs, 200'(0));
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_job(vecs[i], i);
      if (vecs[i].exp_done_cyc != 0)
        chk($sformatf("v%0d_done_cycle", i), 200'(s_done_cyc), 200'(vecs[i].exp_done_cyc));
      chk($sformatf("v%0d_done_count", i), 200'(s_done), 200'(1));
      chk($sformatf("v%0d_ld_beats", i), 200'(s_ld), 200'(vecs[i].exp_beats));
      chk($sformatf("v%0d_st_beats", i), 200'(s_st), 200'(vecs[i].exp_beats));
      chk($sformatf("v%0d_kern_starts", i), 200'(s_kern), 200'(vecs[i].exp_kern));
      chk($sformatf("v%0d_rd_reqs", i), 200'(s_rd_hs), 200'(vecs[i].exp_kern));
      chk($sformatf("v%0d_wr_reqs", i), 200'(s_wr_hs), 200'(vecs[i].exp_kern));
      if (vecs[i].exp_kern > 0) begin
        chk($sformatf("v%0d_rd_last_idx", i), 200'(s_rd_last), 200'(vecs[i].exp_rd_last));
        chk($sformatf("v%0d_wr_last_idx", i), 200'(s_wr_last), 200'(vecs[i].exp_wr_last));
      end
      chk($sformatf("v%0d_dbg_state", i), 200'(s_dbg_done[31:29]), 200'(3'd6));
      chk($sformatf("v%0d_dbg_err", i), 200'(s_dbg_done[28]), 200'(0));
      chk($sformatf("v%0d_dbg_chunk", i), 200'(s_dbg_done[15:0]), 200'(vecs[i].exp_kern));
    end

    // Reset during STORE: abort with all outputs low and no acc_done afterwards.
    @(negedge clk);
    cfg_in_base = 32'h100; cfg_out_base = 32'h800; cfg_num_chunks = 16'd1; cfg_chunk_len = 16'd4;
    kern_done = 1'b1;
    acc_start = 1'b1;
    @(posedge clk);
    #1;
    acc_start = 1'b0;
    cyc = 0;
    seen_st = 0;
    while (!seen_st && cyc < 50) begin
      cyc++;
      if (st_rd) seen_st = 1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    chk("rst_reached_store", 200'(seen_st), 200'(1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    outs = 200'({dma_read_ctrl_val, dma_read_ctrl_msg, dma_read_chnl_rdy, ld_wr,
                 dma_write_ctrl_val, dma_write_ctrl_msg, dma_write_chnl_val, st_rd,
                 kern_start, acc_done, debug});
    chk("rst_mid_outputs", outs, 200'(0));
    rst = 1'b0;
    dcount = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (acc_done) dcount++;
    end
    chk("rst_no_done", 200'(dcount), 200'(0));
    kern_done = 1'b0;

`ifdef HU_AUDIODEC_SCHED_WDOG_EN
    begin
      vec_t w;
      w = '{32'h100, 32'h800, 1, 4, 3, 4, 32'h100, 32'h800, 4, 1, 0};
      run_job(w, 99);
      chk("wdog_done_window", 200'(s_done_cyc >= 100 && s_done_cyc <= 112), 200'(1));
      chk("wdog_err_bit", 200'(s_dbg_done[28]), 200'(1));
      chk("wdog_done_count", 200'(s_done), 200'(1));
      chk("wdog_no_store", 200'(s_st), 200'(0));
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
